// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-approach signal phase sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } state_t;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] E = 2'd1;
    localparam logic [1:0] S = 2'd2;
    localparam logic [1:0] W = 2'd3;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Lowest-index set bit of a request vector; 0 when the vector is empty.
    function automatic logic [1:0] lowest_req(input logic [3:0] req);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter advanced by an enable strobe; expire marks the last tick of an interval.
module phase_timer #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q > CNT_W'(1))) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign expire = en && (count_q == CNT_W'(1));

endmodule

// File: rtl/signal_phase_sequencer.sv
// Green/yellow/all-red phase sequencer for N, E, S, W approaches, timed in external ticks.
// Optional emergency preemption is built when EMG_PREEMPT_EN is defined.
module signal_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int MIN_GREEN = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [CNT_W-1:0] TGn,
    input  logic [CNT_W-1:0] TGe,
    input  logic [CNT_W-1:0] TGs,
    input  logic [CNT_W-1:0] TGw,
`ifdef EMG_PREEMPT_EN
    input  logic [3:0]       emg_req,
`endif
    output logic [3:0]       p_s,
    output logic [2:0]       lt_n,
    output logic [2:0]       lt_e,
    output logic [2:0]       lt_s,
    output logic [2:0]       lt_w,
    output logic [CNT_W-1:0] time_left,
    output logic             cycle_done
);

    state_t           state_q, state_d;
    logic [1:0]       ph_q, ph_d;
    logic             cycle_done_q, cycle_done_d;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             timer_en;
    logic             expire;
    logic [CNT_W-1:0] tg_sel;
    logic [CNT_W-1:0] green_load;
    logic             preempt;
    logic             green_hold;
    logic [1:0]       next_ph;
    logic [2:0]       lamp [4];

`ifdef EMG_PREEMPT_EN
    assign preempt    = (state_q == GREEN) && (emg_req != 4'd0) && !emg_req[ph_q];
    assign green_hold = (state_q == GREEN) && emg_req[ph_q];
    assign next_ph    = (emg_req != 4'd0) ? lowest_req(emg_req) : ph_q + 2'd1;
`else
    assign preempt    = 1'b0;
    assign green_hold = 1'b0;
    assign next_ph    = ph_q + 2'd1;
`endif

    always_comb begin
        tg_sel = TGn;
        case (ph_q)
            N:       tg_sel = TGn;
            E:       tg_sel = TGe;
            S:       tg_sel = TGs;
            default: tg_sel = TGw;
        endcase
    end

    assign green_load = (tg_sel < CNT_W'(MIN_GREEN)) ? CNT_W'(MIN_GREEN) : tg_sel;
    assign timer_en   = tick && !green_hold;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_T)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (timer_en),
        .load     (timer_load),
        .load_val (timer_load_val),
        .count    (time_left),
        .expire   (expire)
    );

    always_comb begin
        state_d        = state_q;
        ph_d           = ph_q;
        cycle_done_d   = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = '0;
        case (state_q)
            ALL_RED: begin
                if (expire) begin
                    state_d        = GREEN;
                    timer_load     = 1'b1;
                    timer_load_val = green_load;
                end
            end
            GREEN: begin
                // Preemption cuts the green on the very next clock, independent of tick.
                if (expire || preempt) begin
                    state_d        = YELLOW;
                    timer_load     = 1'b1;
                    timer_load_val = CNT_W'(YELLOW_T);
                end
            end
            YELLOW: begin
                if (expire) begin
                    state_d        = ALL_RED;
                    ph_d           = next_ph;
                    cycle_done_d   = (ph_q == W);
                    timer_load     = 1'b1;
                    timer_load_val = CNT_W'(ALLRED_T);
                end
            end
            default: begin
                state_d = ALL_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ALL_RED;
            ph_q         <= N;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
            assign lamp[gi] = (ph_q != 2'(gi))    ? RED :
                              (state_q == GREEN)  ? GRN :
                              (state_q == YELLOW) ? YEL : RED;
        end
    endgenerate

    assign lt_n       = lamp[0];
    assign lt_e       = lamp[1];
    assign lt_s       = lamp[2];
    assign lt_w       = lamp[3];
    assign p_s        = 4'b0001 << ph_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_signal_phase_sequencer.sv
// Scoreboard bench: expected per-tick outputs are queued per cycle and compared after each tick edge.
module tb_signal_phase_sequencer;

    localparam int ST_R = 0;
    localparam int ST_G = 1;
    localparam int ST_Y = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] TGn = 8'd10, TGe = 8'd6, TGs = 8'd8, TGw = 8'd7;
    logic [3:0] p_s;
    logic [2:0] lt_n, lt_e, lt_s, lt_w;
    logic [7:0] time_left;
    logic       cycle_done;
`ifdef EMG_PREEMPT_EN
    logic [3:0] emg_req = 4'd0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    signal_phase_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .TGn        (TGn),
        .TGe        (TGe),
        .TGs        (TGs),
        .TGw        (TGw),
`ifdef EMG_PREEMPT_EN
        .emg_req    (emg_req),
`endif
        .p_s        (p_s),
        .lt_n       (lt_n),
        .lt_e       (lt_e),
        .lt_s       (lt_s),
        .lt_w       (lt_w),
        .time_left  (time_left),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end else begin
            $display("ok   %s %h", tag, got);
        end
    endtask

    function automatic logic [31:0] mk(input int st, input int ph, input int tl, input bit cd);
        logic [2:0] l [4];
        logic [3:0] ps;
        ps = 4'b0001 << ph;
        for (int a = 0; a < 4; a++) begin
            if (a == ph && st == ST_G)      l[a] = 3'b001;
            else if (a == ph && st == ST_Y) l[a] = 3'b010;
            else                            l[a] = 3'b100;
        end
        return {7'd0, ps, l[0], l[1], l[2], l[3], 8'(tl), cd};
    endfunction

    function automatic logic [31:0] obs();
        return {7'd0, p_s, lt_n, lt_e, lt_s, lt_w, time_left, cycle_done};
    endfunction

    task automatic push_cycle(input int gn, input int ge, input int gs, input int gw);
        int g [4];
        g[0] = gn; g[1] = ge; g[2] = gs; g[3] = gw;
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = g[ph]; k >= 1; k--) exp_q.push_back(mk(ST_G, ph, k, 1'b0));
            for (int k = 3; k >= 1; k--)     exp_q.push_back(mk(ST_Y, ph, k, 1'b0));
            exp_q.push_back(mk(ST_R, (ph + 1) % 4, 1, ph == 3));
        end
    endtask

    task automatic step(input string tag, input bit t);
        logic [31:0] e;
        tick = t;
        @(posedge clk);
        #1;
        if (t) begin
            if (exp_q.size() == 0) begin
                check_eq({tag, "_underrun"}, obs(), last_exp);
            end else begin
                e = exp_q.pop_front();
                check_eq(tag, obs(), e);
                last_exp = {e[31:1], 1'b0};
            end
        end else begin
            check_eq({tag, "_hold"}, obs(), last_exp);
        end
    endtask

    task automatic drain(input string tag);
        int budget = 2000;
        while (exp_q.size() > 0 && budget > 0) begin
            step(tag, 1'b1);
            budget--;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        last_exp = mk(ST_R, 0, 1, 1'b0);
        check_eq("reset", obs(), last_exp);
    endtask

    initial begin
        #1;
        do_reset(2);

        // Full cycle, continuous tick.
        push_cycle(10, 6, 8, 7);
        drain("cycle");

        // Clamp: E green is 5 for TGe=2 and TGe=0.
        TGe = 8'd2;
        push_cycle(10, 5, 8, 7);
        drain("clamp2");
        TGe = 8'd0;
        push_cycle(10, 5, 8, 7);
        drain("clamp0");
        TGe = 8'd6;

        // Tick every 4th clock.
        push_cycle(10, 6, 8, 7);
        begin
            int budget = 2000;
            while (exp_q.size() > 0 && budget > 0) begin
                step("gate", 1'b0);
                step("gate", 1'b0);
                step("gate", 1'b0);
                step("gate", 1'b1);
                budget--;
            end
        end

        // TGn changes during the running N green.
        push_cycle(10, 6, 8, 7);
        repeat (3) step("sample", 1'b1);
        TGn = 8'd20;
        drain("sample");
        push_cycle(20, 6, 8, 7);
        drain("sample20");
        TGn = 8'd10;

        // Reset in S yellow.
        push_cycle(10, 6, 8, 7);
        repeat (14 + 10 + 8 + 1) step("to_s_yel", 1'b1);
        check_eq("in_s_yellow", obs(), mk(ST_Y, 2, 3, 1'b0));
        tick = 1'b1;
        do_reset(1);
        tick = 1'b0;

`ifdef EMG_PREEMPT_EN
        step("emg_pre", 1'b1);
        step("emg_pre", 1'b1);
        step("emg_pre", 1'b1);
        check_eq("emg_tl8", obs(), mk(ST_G, 0, 8, 1'b0));
        emg_req = 4'b0100;
        tick = 1'b0;
        @(posedge clk); #1;
        check_eq("emg_yellow", obs(), mk(ST_Y, 0, 3, 1'b0));
        tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("emg_allred_s", obs(), mk(ST_R, 2, 1, 1'b0));
        @(posedge clk); #1;
        check_eq("emg_s_green", obs(), mk(ST_G, 2, 8, 1'b0));
        repeat (20) @(posedge clk);
        #1;
        check_eq("emg_s_hold", obs(), mk(ST_G, 2, 8, 1'b0));
        emg_req = 4'd0;
        tick = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/signal_phase_sequencer.md
Name: signal_phase_sequencer

Overview:
Four-approach traffic signal phase controller that sequences green, yellow and all-red intervals for the N, E, S and W approaches. Green durations come from the adaptation block's TGn/TGe/TGs/TGw outputs. The block drives p_s back to the adaptation block and drives the lamp outputs. Timing is counted in ticks of an external tick strobe, not in clocks.

Parameters:
CNT_W, 8, width of green-time inputs and the internal timer
YELLOW_T, 3, yellow interval in ticks (must be >=1)
ALLRED_T, 1, all-red clearance interval in ticks (must be >=1)
MIN_GREEN, 5, minimum green in ticks; smaller TG values are clamped up to this (must be >=1)

Ports:
clk  in  1  system clock, all logic on its rising edge
reset  in  1  synchronous, active-high reset
tick  in  1  one-clock timing strobe; timer advances only when high
TGn  in  CNT_W  green time for N, in ticks
TGe  in  CNT_W  green time for E, in ticks
TGs  in  CNT_W  green time for S, in ticks
TGw  in  CNT_W  green time for W, in ticks
p_s  out  4  one-hot current/next approach (bit0=N, bit1=E, bit2=S, bit3=W), fed to adaptation
lt_n  out  3  N lamp, {R,Y,G} one-hot
lt_e  out  3  E lamp, {R,Y,G} one-hot
lt_s  out  3  S lamp, {R,Y,G} one-hot
lt_w  out  3  W lamp, {R,Y,G} one-hot
time_left  out  CNT_W  remaining ticks in the current interval
cycle_done  out  1  one-clock pulse when a full N-E-S-W cycle completes

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset is sampled on the clk edge and has priority over tick.
- Reset values: state=ALL_RED, ph=0 (N), p_s=4'b0001, all lamps 3'b100, time_left=ALLRED_T, cycle_done=0.
- States: ALL_RED, GREEN, YELLOW. The approach index ph is 0..3.
- Timer rule: an interval loaded with value T lasts exactly T ticks.
  - On each edge with tick=1 and timer>1: timer decrements.
  - On the edge with tick=1 and timer==1: state transitions and the next interval is loaded.
  - With tick=0: all state and outputs hold.
- ALL_RED -> GREEN:
  - Sample TG[ph] at this edge.
  - Load max(TG[ph], MIN_GREEN); TG=0 loads MIN_GREEN.
  - Later changes on TG inputs do not affect the running green.
- GREEN -> YELLOW: load YELLOW_T.
- YELLOW -> ALL_RED:
  - Load ALLRED_T; ph advances to (ph+1) mod 4; p_s updates at the same edge.
  - If the old ph was 3, cycle_done=1 for exactly that one clock.
- Lamps:
  - Approach ph shows G in GREEN and Y in YELLOW.
  - All other approaches show R.
  - All approaches show R in ALL_RED.
  - Never more than one approach shows non-red.
- time_left equals the timer register, registered, and updates on the same edge as the state.
- tick held high continuously: one decrement per clock, with no skipped or double counts.
- Reset mid-interval (any state): the next edge returns to the reset values; the partial interval is discarded.

Optional Feature:
EMG_PREEMPT_EN
- Defined: adds input emg_req[3:0], one bit per approach.
  - GREEN with emg_req!=0 and emg_req[ph]==0: go to YELLOW on the next clock edge, not tick-gated.
  - GREEN with emg_req[ph]==1: the timer holds while the request stays high.
  - At YELLOW -> ALL_RED with emg_req!=0: next ph = lowest-index requested approach instead of ph+1.
  - cycle_done pulses whenever the departing ph is 3.
- Not defined: no port, and behaviour is exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - state enum {ALL_RED, GREEN, YELLOW}
  - approach indices N=0, E=1, S=2, W=3
  - lamp encodings RED=3'b100, YEL=3'b010, GRN=3'b001
- One sub-module, phase_timer: a loadable down-counter of width CNT_W with tick enable and an expire flag (tick && count==1).

Test Plan:
1. Reset: hold reset for 2 clocks -> all lamps 100, p_s=0001, time_left=1, cycle_done=0; assert reset again mid-S-yellow -> the next edge gives the same values.
2. Full cycle: TGn=10, TGe=6, TGs=8, TGw=7, tick=1 always.
   - N green 10 clocks, yellow 3, all-red 1, then E green 6, and so on.
   - cycle_done pulses on the 47th tick edge; p_s returns to 0001 on that same edge.
3. Clamp: TGe=2 and then TGe=0 -> E green lasts 5 ticks in both cycles.
4. Tick gating: tick high every 4th clock, TGn=10 -> N green spans 40 clocks; time_left steps 10..1 once per tick; all outputs are stable between ticks.
5. Sampling: TGn changes 10->20 during the third tick of N green -> the current green still ends after 10 ticks; the next cycle's N green lasts 20.
6. (EMG_PREEMPT_EN) During N green with time_left=8, raise emg_req=0100 -> N goes yellow on the next clock, then all-red, then S green (p_s=0100); holding emg_req[2] high keeps S green indefinitely.
